axi_interconnect_crossbar_arbit_polling: RTL and testbench

//  - Round-robin (polling) arbiter for the AXI interconnect crossbar; one instance per slave-side channel.
//  - Picks the next requesting user after the previous winner, with zero-cycle (combinational) grant.
//  - Also keeps a registered copy of the last winner and a grant flag for downstream channel muxes.

---
 rtl/axi_interconnect_pkg.sv | 15 +
 rtl/axi_interconnect_arbit_rr_pick.sv | 58 +++++
 rtl/axi_interconnect_crossbar_arbit_polling.sv | 77 +++++++
 tb/tb_axi_interconnect_crossbar_arbit_polling.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/axi_interconnect_pkg.sv
// Shared definitions for the AXI interconnect crossbar.
//   ARB_NUM_DEFAULT : default number of requesters per arbiter
//   ARB_IDX_W()     : index width for a given requester count (clog2 wrapper, minimum 1)
//   arb_idx_t       : arbiter index type at the default size, shared with the crossbar muxes
package axi_interconnect_pkg;

  localparam int unsigned ARB_NUM_DEFAULT = 8;

  function automatic int unsigned ARB_IDX_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [$clog2(ARB_NUM_DEFAULT)-1:0] arb_idx_t;

endpackage

// File: rtl/axi_interconnect_arbit_rr_pick.sv
// Combinational round-robin pick.
// Rotates the request vector so that the user after last_user lands at bit 0, runs a
// fixed-priority find-first-one, then maps the position back to an absolute index.
//   user_req     in  NUM    request vector
//   last_user    in  WIDTH  previous winner (lowest priority this round)
//   current_user out WIDTH  winner index; equals last_user when nobody requests
//   grant_vld    out 1      any request present
module axi_interconnect_arbit_rr_pick
  import axi_interconnect_pkg::*;
#(
  parameter int unsigned NUM = ARB_NUM_DEFAULT,
  localparam int unsigned WIDTH = ARB_IDX_W(NUM)
) (
  input  logic [NUM-1:0]   user_req,
  input  logic [WIDTH-1:0] last_user,
  output logic [WIDTH-1:0] current_user,
  output logic             grant_vld
);

  localparam logic [WIDTH:0] NumW  = (WIDTH+1)'(NUM);
  localparam logic [WIDTH:0] NumM1 = (WIDTH+1)'(NUM - 1);

  logic [WIDTH:0]   start;
  logic [WIDTH:0]   ffo;
  logic [WIDTH:0]   sum;
  logic [NUM-1:0]   rot;

  always_comb begin
    // An out-of-range last_user (non power-of-2 NUM) restarts the search at index 0.
    if ({1'b0, last_user} >= NumM1) begin
      start = '0;
    end else begin
      start = {1'b0, last_user} + (WIDTH+1)'(1);
    end

    rot = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      rot[i] = user_req[WIDTH'((int'(start) + i) % NUM)];
    end

    // Scan downwards so the lowest set position wins.
    ffo = '0;
    for (int i = int'(NUM) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ffo = (WIDTH+1)'(i);
      end
    end

    sum = start + ffo;
    if (sum >= NumW) begin
      sum = sum - NumW;
    end

    grant_vld    = |user_req;
    current_user = grant_vld ? sum[WIDTH-1:0] : last_user;
  end

endmodule

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
// Round-robin (polling) arbiter, one per slave-side crossbar channel.
// Zero-latency combinational grant plus a registered copy of the last winner.
//   clk_sys       in  1      system clock
//   rst_n         in  1      asynchronous active-low reset
//   user_req      in  NUM    request vector
//   last_user     in  WIDTH  previous winner supplied by the owner
//   current_user  out WIDTH  combinational winner index
//   grant_vld     out 1      combinational, =|user_req
//   grant_onehot  out NUM    one-hot of current_user, zero when grant_vld=0
//   last_grant_q  out WIDTH  winner of the most recent cycle with grant_vld=1
// Optional macro ARBIT_POLLING_CHECK_EN adds simulation-only consistency checks.
module axi_interconnect_crossbar_arbit_polling
  import axi_interconnect_pkg::*;
#(
  parameter int unsigned NUM = ARB_NUM_DEFAULT,
  localparam int unsigned WIDTH = ARB_IDX_W(NUM)
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [NUM-1:0]   user_req,
  input  logic [WIDTH-1:0] last_user,
  output logic [WIDTH-1:0] current_user,
  output logic             grant_vld,
  output logic [NUM-1:0]   grant_onehot,
  output logic [WIDTH-1:0] last_grant_q
);

  axi_interconnect_arbit_rr_pick #(
    .NUM (NUM)
  ) u_pick (
    .user_req     (user_req),
    .last_user    (last_user),
    .current_user (current_user),
    .grant_vld    (grant_vld)
  );

  always_comb begin
    grant_onehot = '0;
    if (grant_vld) begin
      grant_onehot = {{(NUM-1){1'b0}}, 1'b1} << current_user;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= '0;
    end else if (grant_vld) begin
      last_grant_q <= current_user;
    end
  end

`ifdef ARBIT_POLLING_CHECK_EN
  always @(posedge clk_sys) begin
    if (rst_n) begin
      if (grant_vld && !user_req[current_user]) begin
        $error("%0t: arbiter granted non-requesting user %0d", $time, current_user);
      end
      if ((grant_onehot & (grant_onehot - 1'b1)) != '0) begin
        $error("%0t: arbiter grant_onehot not one-hot: %h", $time, grant_onehot);
      end
      if (grant_vld) begin
        int unsigned s;
        int unsigned p;
        s = (int'(last_user) >= int'(NUM) - 1) ? 0 : int'(last_user) + 1;
        for (int unsigned k = 0; k < NUM; k++) begin
          p = (s + k) % NUM;
          if (p == int'(current_user)) break;
          if (user_req[WIDTH'(p)]) begin
            $error("%0t: arbiter skipped requester %0d before %0d", $time, p, current_user);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_interconnect_crossbar_arbit_polling.sv
module tb_axi_interconnect_crossbar_arbit_polling;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] user_req  = '0;
  logic [2:0] last_user = '0;
  logic [2:0] current_user;
  logic       grant_vld;
  logic [7:0] grant_onehot;
  logic [2:0] last_grant_q;

  axi_interconnect_crossbar_arbit_polling #(
    .NUM (8)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .user_req     (user_req),
    .last_user    (last_user),
    .current_user (current_user),
    .grant_vld    (grant_vld),
    .grant_onehot (grant_onehot),
    .last_grant_q (last_grant_q)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         tag;
    logic [2:0] cu;
    logic       vld;
    logic [7:0] oh;
    logic [2:0] lg;
  } vec_t;

  vec_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   tag_n       = 0;
  logic [2:0] model_lg = '0;
  logic       prev_vld = 1'b0;
  logic [2:0] prev_cu  = '0;

  // Reference search: walk last_user+1, +2, ... wrapping; last_user itself is checked last.
  function automatic logic [2:0] ref_pick(input logic [7:0] req, input logic [2:0] lu);
    logic [2:0] p;
    if (req == 8'h00) return lu;
    for (int k = 1; k <= 8; k++) begin
      p = lu + 3'(k);
      if (req[p]) return p;
    end
    return lu;
  endfunction

  // Drives one vector just after a rising edge and queues what the DUT must show.
  // With use_loop set, last_user is taken from the modelled last_grant_q.
  task automatic apply(input logic [7:0] req, input logic [2:0] lu, input logic [2:0] exp_cu,
                       input bit use_loop);
    vec_t v;
    @(posedge clk_sys);
    #1;
    if (prev_vld) model_lg = prev_cu;
    if (use_loop) lu = model_lg;
    user_req  = req;
    last_user = lu;
    v.tag = tag_n;
    tag_n++;
    v.cu  = exp_cu;
    v.vld = (req != 8'h00);
    v.oh  = v.vld ? (8'h01 << exp_cu) : 8'h00;
    v.lg  = model_lg;
    prev_vld = v.vld;
    prev_cu  = exp_cu;
    q.push_back(v);
  endtask

  task automatic mid_reset();
    @(posedge clk_sys);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (last_grant_q !== 3'd0 || current_user !== prev_cu) begin
      miscompares++;
      $display("FAIL mid_reset: last_grant_q=%0d current_user=%0d, required 0 and %0d",
               last_grant_q, current_user, prev_cu);
    end
    model_lg = '0;
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  // Monitor: compare queued expectations on the falling edge.
  initial begin
    vec_t v;
    forever begin
      @(negedge clk_sys);
      if (q.size() != 0) begin
        v = q.pop_front();
        vectors++;
        if (current_user !== v.cu || grant_vld !== v.vld || grant_onehot !== v.oh ||
            last_grant_q !== v.lg) begin
          miscompares++;
          $display("FAIL vec%0d: cu=%0d vld=%0b oh=%h lg=%0d, required cu=%0d vld=%0b oh=%h lg=%0d",
                   v.tag, current_user, grant_vld, grant_onehot, last_grant_q,
                   v.cu, v.vld, v.oh, v.lg);
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic [2:0] l;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Reset state, idle.
    apply(8'h00, 3'd0, 3'd0, 1'b0);
    // Closed loop, everyone requesting: winners 1..7 then 0.
    apply(8'hFF, 3'd0, 3'd1, 1'b1);
    apply(8'hFF, 3'd0, 3'd2, 1'b1);
    apply(8'hFF, 3'd0, 3'd3, 1'b1);
    apply(8'hFF, 3'd0, 3'd4, 1'b1);
    apply(8'hFF, 3'd0, 3'd5, 1'b1);
    apply(8'hFF, 3'd0, 3'd6, 1'b1);
    apply(8'hFF, 3'd0, 3'd7, 1'b1);
    apply(8'hFF, 3'd0, 3'd0, 1'b1);
    // Directed corner cases.
    apply(8'h11, 3'd3, 3'd4, 1'b0);
    apply(8'h81, 3'd7, 3'd0, 1'b0);
    apply(8'h20, 3'd5, 3'd5, 1'b0);
    apply(8'h00, 3'd2, 3'd2, 1'b0);
    apply(8'h40, 3'd6, 3'd6, 1'b0);
    apply(8'h01, 3'd0, 3'd0, 1'b0);
    apply(8'h80, 3'd0, 3'd7, 1'b0);
    apply(8'h3F, 3'd6, 3'd0, 1'b0);
    apply(8'h03, 3'd1, 3'd0, 1'b0);
    apply(8'h06, 3'd1, 3'd2, 1'b0);
    apply(8'h00, 3'd7, 3'd7, 1'b0);

    // Random vectors against the reference search, with a reset pulse mid-run.
    for (int n = 0; n < 10000; n++) begin
      r = 8'($urandom_range(0, 255));
      if (n % 4 == 0) r = r & 8'($urandom_range(0, 255));
      l = 3'($urandom_range(0, 7));
      apply(r, l, ref_pick(r, l), 1'b0);
      if (n == 5000) mid_reset();
    end

    @(negedge clk_sys);
    repeat (20) begin
      if (q.size() == 0) break;
      @(negedge clk_sys);
    end
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
